// File: rtl/regfile_2r1w_if.sv
// rtl/regfile_2r1w_if.sv - write/read port bundle for the 2-read 1-write register file
interface regfile_2r1w_if #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 16
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic                 en;
    logic [AW-1:0]        wr_addr;
    logic [WIDTH/8-1:0]   wr_mask;
    logic [WIDTH-1:0]     in;
    logic                 clr;
    logic                 read_a;
    logic [AW-1:0]        rd_addr_a;
    logic [WIDTH-1:0]     out_a;
    logic                 valid_a;
    logic                 read_b;
    logic [AW-1:0]        rd_addr_b;
    logic [WIDTH-1:0]     out_b;
    logic                 valid_b;

    modport master (
        output en, wr_addr, wr_mask, in, clr,
        output read_a, rd_addr_a, read_b, rd_addr_b,
        input  out_a, valid_a, out_b, valid_b
    );

    modport slave (
        input  en, wr_addr, wr_mask, in, clr,
        input  read_a, rd_addr_a, read_b, rd_addr_b,
        output out_a, valid_a, out_b, valid_b
    );
endinterface

// File: rtl/regfile_2r1w.sv
// rtl/regfile_2r1w.sv - byte-masked register file with two registered read ports
module regfile_2r1w #(
    parameter int WIDTH    = 64,
    parameter int DEPTH    = 16,
    parameter int ZERO_REG = 0,
    parameter int BYPASS   = 1
) (
    input  logic           clk,
    input  logic           rst_n,
    regfile_2r1w_if.slave  bus
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int NB = WIDTH / 8;
    localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];

    logic             wr_legal;
    logic             wr_hit;
    logic [AW-1:0]    wr_idx;
    logic [WIDTH-1:0] wr_bits;
    logic [WIDTH-1:0] wr_merged;

    logic [1:0]       rd_req;
    logic [AW-1:0]    rd_addr [2];
    logic [AW-1:0]    rd_idx  [2];
    logic [1:0]       rd_legal;
    logic [1:0]       rd_zero;
    logic [WIDTH-1:0] rd_next [2];
    logic [WIDTH-1:0] out_q   [2];
    logic [1:0]       valid_q;

    assign rd_req     = {bus.read_b, bus.read_a};
    assign rd_addr[0] = bus.rd_addr_a;
    assign rd_addr[1] = bus.rd_addr_b;

    // A write that would be dropped anyway never counts as a hit, so it can't bypass.
    always_comb begin
        wr_legal = {1'b0, bus.wr_addr} < DEPTH_C;
        wr_idx   = wr_legal ? bus.wr_addr : '0;
        wr_hit   = bus.en && !bus.clr && wr_legal && (|bus.wr_mask)
                   && !((ZERO_REG != 0) && (bus.wr_addr == '0));
        wr_bits  = '0;
        for (int b = 0; b < NB; b++) begin
            wr_bits[8*b +: 8] = {8{bus.wr_mask[b]}};
        end
        wr_merged = (mem[wr_idx] & ~wr_bits) | (bus.in & wr_bits);
    end

    always_comb begin
        for (int p = 0; p < 2; p++) begin
            rd_legal[p] = {1'b0, rd_addr[p]} < DEPTH_C;
            rd_zero[p]  = (ZERO_REG != 0) && (rd_addr[p] == '0);
            rd_idx[p]   = rd_legal[p] ? rd_addr[p] : '0;
            rd_next[p]  = mem[rd_idx[p]];
            if (BYPASS != 0) begin
                if (bus.clr) begin
                    rd_next[p] = '0;
                end else if (wr_hit && (bus.wr_addr == rd_addr[p])) begin
                    rd_next[p] = wr_merged;
                end
            end
            if (!rd_legal[p] || rd_zero[p]) begin
                rd_next[p] = '0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            out_q[0] <= '0;
            out_q[1] <= '0;
            valid_q  <= '0;
        end else begin
            if (bus.clr) begin
                for (int i = 0; i < DEPTH; i++) begin
                    mem[i] <= '0;
                end
            end else if (wr_hit) begin
                mem[wr_idx] <= wr_merged;
            end
            // Out-of-range reads still load zero into the data register but stay invalid.
            for (int p = 0; p < 2; p++) begin
                if (rd_req[p]) begin
                    out_q[p]   <= rd_next[p];
                    valid_q[p] <= rd_legal[p];
                end else begin
                    valid_q[p] <= 1'b0;
                end
            end
        end
    end

    assign bus.out_a   = out_q[0];
    assign bus.out_b   = out_q[1];
    assign bus.valid_a = valid_q[0];
    assign bus.valid_b = valid_q[1];
endmodule

// File: tb/tb_regfile_2r1w.sv
// tb/tb_regfile_2r1w.sv - bench for regfile_2r1w, two configurations on shared stimulus
module tb_regfile_2r1w;
    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    bit   clk_en = 1'b1;
    bit   cmp_on = 1'b0;
    int   n_pass  = 0;
    int   n_total = 0;

    always #5 if (clk_en) clk = ~clk;

    logic        s_en, s_clr, s_ra, s_rb;
    logic [3:0]  s_wa, s_raa, s_rba;
    logic [7:0]  s_wm;
    logic [63:0] s_in;

    regfile_2r1w_if #(.WIDTH(64), .DEPTH(16)) bus0 ();
    regfile_2r1w_if #(.WIDTH(64), .DEPTH(10)) bus1 ();

    assign bus0.en = s_en;       assign bus1.en = s_en;
    assign bus0.clr = s_clr;     assign bus1.clr = s_clr;
    assign bus0.wr_addr = s_wa;  assign bus1.wr_addr = s_wa;
    assign bus0.wr_mask = s_wm;  assign bus1.wr_mask = s_wm;
    assign bus0.in = s_in;       assign bus1.in = s_in;
    assign bus0.read_a = s_ra;   assign bus1.read_a = s_ra;
    assign bus0.rd_addr_a = s_raa; assign bus1.rd_addr_a = s_raa;
    assign bus0.read_b = s_rb;   assign bus1.read_b = s_rb;
    assign bus0.rd_addr_b = s_rba; assign bus1.rd_addr_b = s_rba;

    regfile_2r1w #(.WIDTH(64), .DEPTH(16), .ZERO_REG(0), .BYPASS(1)) dut0 (
        .clk(clk), .rst_n(rst_n), .bus(bus0));
    regfile_2r1w #(.WIDTH(64), .DEPTH(10), .ZERO_REG(1), .BYPASS(0)) dut1 (
        .clk(clk), .rst_n(rst_n), .bus(bus1));

    function automatic int dep(int c); return (c == 0) ? 16 : 10; endfunction
    function automatic bit zr(int c);  return c == 1; endfunction
    function automatic bit bp(int c);  return c == 0; endfunction

    function automatic logic [63:0] dout(int c, int p);
        if (c == 0) return (p == 0) ? bus0.out_a : bus0.out_b;
        return (p == 0) ? bus1.out_a : bus1.out_b;
    endfunction

    function automatic logic [63:0] dval(int c, int p);
        if (c == 0) return {63'd0, (p == 0) ? bus0.valid_a : bus0.valid_b};
        return {63'd0, (p == 0) ? bus1.valid_a : bus1.valid_b};
    endfunction

    task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", nm, act, exp);
    endtask

    // Reference model: word arrays updated from the architectural rules.
    logic [63:0] m     [2][16];
    logic [63:0] nm    [16];
    logic [63:0] e_out [2][2];
    logic        e_val [2][2];

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int c = 0; c < 2; c++) begin
                for (int i = 0; i < 16; i++) m[c][i] = '0;
                for (int p = 0; p < 2; p++) begin e_out[c][p] = '0; e_val[c][p] = 1'b0; end
            end
        end else begin
            for (int c = 0; c < 2; c++) begin
                for (int i = 0; i < 16; i++) nm[i] = s_clr ? 64'd0 : m[c][i];
                if (!s_clr && s_en && (int'(s_wa) < dep(c)) && !(zr(c) && s_wa == 0))
                    for (int b = 0; b < 8; b++)
                        if (s_wm[b]) nm[s_wa][8*b +: 8] = s_in[8*b +: 8];
                for (int p = 0; p < 2; p++) begin
                    logic       req;
                    logic [3:0] a;
                    req = (p == 0) ? s_ra : s_rb;
                    a   = (p == 0) ? s_raa : s_rba;
                    if (!req) e_val[c][p] = 1'b0;
                    else if (int'(a) >= dep(c)) begin e_out[c][p] = '0; e_val[c][p] = 1'b0; end
                    else if (zr(c) && a == 0)   begin e_out[c][p] = '0; e_val[c][p] = 1'b1; end
                    else begin
                        e_out[c][p] = bp(c) ? nm[a] : m[c][a];
                        e_val[c][p] = 1'b1;
                    end
                end
                for (int i = 0; i < 16; i++) m[c][i] = nm[i];
            end
        end
    end

    always @(negedge clk) begin
        if (cmp_on) begin
            for (int c = 0; c < 2; c++)
                for (int p = 0; p < 2; p++) begin
                    chk($sformatf("model_c%0d_p%0d_out", c, p), dout(c, p), e_out[c][p]);
                    chk($sformatf("model_c%0d_p%0d_valid", c, p), dval(c, p), {63'd0, e_val[c][p]});
                end
        end
    end

    task automatic idle();
        s_en = 1'b0; s_clr = 1'b0; s_ra = 1'b0; s_rb = 1'b0;
    endtask
    task automatic wr(input logic [3:0] a, input logic [63:0] d, input logic [7:0] mk);
        s_en = 1'b1; s_wa = a; s_in = d; s_wm = mk;
    endtask
    task automatic rda(input logic [3:0] a); s_ra = 1'b1; s_raa = a; endtask
    task automatic rdb(input logic [3:0] a); s_rb = 1'b1; s_rba = a; endtask
    task automatic tick();
        @(posedge clk); @(negedge clk); idle();
    endtask

    initial begin
        idle(); s_wa = '0; s_raa = '0; s_rba = '0; s_wm = '0; s_in = '0;
        #1 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1; cmp_on = 1'b1;

        // Preload, then reset with the clock stopped
        wr(5, 64'hCAFE, 8'hFF); tick();
        rda(5); tick();
        chk("preload_a0", bus0.out_a, 64'hCAFE);
        clk_en = 1'b0;
        #3 rst_n = 1'b0;
        #1;
        chk("async_rst_out_a0", bus0.out_a, 64'd0);
        chk("async_rst_valid_a0", {63'd0, bus0.valid_a}, 64'd0);
        chk("async_rst_out_a1", bus1.out_a, 64'd0);
        chk("async_rst_valid_b1", {63'd0, bus1.valid_b}, 64'd0);
        #20 rst_n = 1'b1;
        rda(5);
        clk_en = 1'b1;
        tick();
        chk("post_rst_out_a0", bus0.out_a, 64'd0);
        chk("post_rst_valid_a0", {63'd0, bus0.valid_a}, 64'd1);

        // Basic write then read, then hold with no read
        wr(3, 64'h59, 8'hFF); tick();
        rda(3); tick();
        chk("wr_rd_out_a", bus0.out_a, 64'h59);
        chk("wr_rd_valid_a", {63'd0, bus0.valid_a}, 64'd1);
        repeat (3) tick();
        chk("hold_out_a", bus0.out_a, 64'h59);
        chk("hold_valid_a", {63'd0, bus0.valid_a}, 64'd0);

        // Byte mask, then an all-zero mask
        wr(2, 64'h1122334455667788, 8'hFF); tick();
        wr(2, 64'hFFFFFFFFFFFFFFFF, 8'h0F); tick();
        rda(2); tick();
        chk("mask_out_a0", bus0.out_a, 64'h11223344FFFFFFFF);
        wr(2, 64'd0, 8'h00); rdb(2); tick();
        chk("mask0_out_b1", bus1.out_b, 64'h11223344FFFFFFFF);

        // Write-to-read on the same edge
        wr(7, 64'h1200, 8'hFF); tick();
        wr(7, 64'hAB, 8'h01); rdb(7); tick();
        chk("bypass_on_out_b0", bus0.out_b, 64'h12AB);
        chk("bypass_off_out_b1", bus1.out_b, 64'h1200);
        rdb(7); tick();
        chk("after_bypass_out_b1", bus1.out_b, 64'h12AB);

        // Clear beats write; read on the clearing edge
        wr(4, 64'h55, 8'hFF); tick();
        s_clr = 1'b1; wr(4, 64'h77, 8'hFF); rda(4); tick();
        chk("clr_bypass_out_a0", bus0.out_a, 64'd0);
        chk("clr_nobypass_out_a1", bus1.out_a, 64'h55);
        rda(4); rdb(2); tick();
        chk("clr_after_out_a1", bus1.out_a, 64'd0);
        chk("clr_after_out_b0", bus0.out_b, 64'd0);

        // Addresses past DEPTH on the 10-deep instance
        wr(1, 64'h31, 8'hFF); tick();
        rda(1); tick();
        wr(12, 64'h99, 8'hFF); rda(12); tick();
        chk("oob_rd_out_a1", bus1.out_a, 64'd0);
        chk("oob_rd_valid_a1", {63'd0, bus1.valid_a}, 64'd0);
        chk("addr12_out_a0", bus0.out_a, 64'h99);
        for (int i = 0; i < 16; i++) begin
            rda(4'(i)); rdb(4'(15 - i)); tick();
        end

        // Hardwired zero location
        wr(0, 64'h59, 8'hFF); tick();
        rda(0); tick();
        chk("zreg_out_a1", bus1.out_a, 64'd0);
        chk("zreg_valid_a1", {63'd0, bus1.valid_a}, 64'd1);
        chk("noz_out_a0", bus0.out_a, 64'h59);
        wr(0, 64'h77, 8'hFF); rdb(0); tick();
        chk("zreg_same_edge_b1", bus1.out_b, 64'd0);

        // Both ports on one address during a masked write
        wr(6, 64'hA5A5A5A5A5A5A5A5, 8'hF0); rda(6); rdb(6); tick();
        chk("dual_out_a0", bus0.out_a, 64'hA5A5A5A500000000);
        chk("dual_out_b0", bus0.out_b, 64'hA5A5A5A500000000);
        chk("dual_out_b1", bus1.out_b, 64'd0);

        // Reset mid-cycle discards the pending write and read
        wr(3, 64'hFFFF, 8'hFF); rda(3);
        #2 rst_n = 1'b0;
        @(posedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk); idle();
        chk("midrst_out_a0", bus0.out_a, 64'd0);
        chk("midrst_valid_a0", {63'd0, bus0.valid_a}, 64'd0);
        rda(3); tick();
        chk("midrst_rd_out_a0", bus0.out_a, 64'd0);
        chk("midrst_rd_valid_a0", {63'd0, bus0.valid_a}, 64'd1);

        cmp_on = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
